// File: rtl/memchk_pkg.sv
// Shared types and constants for the memory-write checker.
package memchk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PASS,
        FAIL
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_DATA    = 2'b01;
    localparam logic [1:0] FC_ADDR    = 2'b10;
    localparam logic [1:0] FC_TIMEOUT = 2'b11;

    // Index width for a table of the given depth; never narrower than one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/memchk_table.sv
// Expected-store table: DEPTH entries of {address, data}, one write port,
// combinational read. Contents are not reset.
module memchk_table
    import memchk_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int IW = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IW-1:0]    widx,
    input  logic [WIDTH-1:0] wadr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IW-1:0]    ridx,
    output logic [WIDTH-1:0] radr,
    output logic [WIDTH-1:0] rdata
);

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [2*WIDTH-1:0] entry;

    always_ff @(posedge clk) begin
        if (we && (int'(widx) < DEPTH))
            mem[widx] <= {wadr, wdata};
    end

    always_comb begin
        entry = '0;
        if (int'(ridx) < DEPTH)
            entry = mem[ridx];
    end

    assign radr  = entry[2*WIDTH-1:WIDTH];
    assign rdata = entry[WIDTH-1:0];

endmodule

// File: rtl/mem_write_checker.sv
// Ordered store checker with timeout and sticky verdict.
// Optional capture of the offending store: define MEMCHK_CAPTURE_EN.
module mem_write_checker
    import memchk_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024,
    localparam int IW = idx_width(DEPTH),
    localparam int CW = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    input  logic             exp_we,
    input  logic [IW-1:0]    exp_idx,
    input  logic [WIDTH-1:0] exp_adr,
    input  logic [WIDTH-1:0] exp_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [IW-1:0]    fail_idx,
    output logic [IW:0]      writes_seen,
    output logic [CW-1:0]    cycle_count,
    output logic [WIDTH-1:0] bad_adr,
    output logic [WIDTH-1:0] bad_data
);

    state_t           state, state_nxt;
    logic [IW-1:0]    ptr;
    logic [WIDTH-1:0] tbl_adr, tbl_data;
    logic             run, store, adr_bad, data_bad, mismatch, match, last, timeout_hit;

    memchk_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_table (
        .clk   (clk),
        .we    (exp_we && (state == IDLE)),
        .widx  (exp_idx),
        .wadr  (exp_adr),
        .wdata (exp_data),
        .ridx  (ptr),
        .radr  (tbl_adr),
        .rdata (tbl_data)
    );

    assign run         = (state == RUN);
    assign store       = run && memwrite && !start;
    // Case inequality so X/Z on the bus is a mismatch in simulation.
    assign adr_bad     = (adr !== tbl_adr);
    assign data_bad    = (writedata !== tbl_data);
    assign mismatch    = store && (adr_bad || data_bad);
    assign match       = store && !adr_bad && !data_bad;
    assign last        = (ptr == IW'(DEPTH - 1));
    assign timeout_hit = run && !start && (cycle_count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start)
            state_nxt = RUN;
        else if (run) begin
            if (mismatch)
                state_nxt = FAIL;
            else if (match && last)
                state_nxt = PASS;
            else if (timeout_hit)
                state_nxt = FAIL;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == PASS) || (state == FAIL);
    assign pass = (state == PASS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr         <= '0;
            writes_seen <= '0;
            cycle_count <= '0;
            fail_code   <= FC_NONE;
            fail_idx    <= '0;
        end else if (start) begin
            ptr         <= '0;
            writes_seen <= '0;
            cycle_count <= '0;
            fail_code   <= FC_NONE;
            fail_idx    <= '0;
        end else if (run) begin
            if (cycle_count != CW'(TIMEOUT))
                cycle_count <= cycle_count + CW'(1);
            if (mismatch) begin
                fail_code <= adr_bad ? FC_ADDR : FC_DATA;
                fail_idx  <= ptr;
            end else begin
                if (match) begin
                    writes_seen <= writes_seen + (IW+1)'(1);
                    if (!last)
                        ptr <= ptr + IW'(1);
                end
                // A final match on the timeout cycle wins over the timeout.
                if (timeout_hit && !(match && last)) begin
                    fail_code <= FC_TIMEOUT;
                    fail_idx  <= match ? ptr + IW'(1) : ptr;
                end
            end
        end
    end

`ifdef MEMCHK_CAPTURE_EN
    logic [WIDTH-1:0] cap_adr, cap_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_adr  <= '0;
            cap_data <= '0;
        end else if (start) begin
            cap_adr  <= '0;
            cap_data <= '0;
        end else if (mismatch) begin
            cap_adr  <= adr;
            cap_data <= writedata;
        end
    end

    assign bad_adr  = cap_adr;
    assign bad_data = cap_data;
`else
    assign bad_adr  = '0;
    assign bad_data = '0;
`endif

endmodule
